// File: rtl/bin2bcd.sv
// Sequential double-dabble: signed binary to sign + BCD magnitude, done WIDTH+1 edges after start.
// No backpressure: start is ignored while busy; results hold until the next done pulse.
module bin2bcd #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      din,
  output logic                  busy,
  output logic                  done,
  output logic                  sign,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] mag;
  logic [BW-1:0]    scratch;
  logic [BW-1:0]    adj;
  logic             sign_l;
  logic             ovf_acc;

  always_comb begin
    adj = '0;
    for (int k = 0; k < DIGITS; k++) begin
      adj[4*k +: 4] = (scratch[4*k +: 4] >= 4'd5) ? scratch[4*k +: 4] + 4'd3
                                                  : scratch[4*k +: 4];
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (cnt == CW'(1)) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      mag      <= '0;
      scratch  <= '0;
      sign_l   <= 1'b0;
      ovf_acc  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sign     <= 1'b0;
      bcd      <= '0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            // Unsigned negate makes the most negative input yield 2^(WIDTH-1).
            sign_l  <= din[WIDTH-1];
            mag     <= din[WIDTH-1] ? -din : din;
            scratch <= '0;
            ovf_acc <= 1'b0;
            cnt     <= CW'(WIDTH);
            busy    <= 1'b1;
          end
        end
        SHIFT: begin
          scratch <= {adj[BW-2:0], mag[WIDTH-1]};
          mag     <= {mag[WIDTH-2:0], 1'b0};
          ovf_acc <= ovf_acc | adj[BW-1];
          cnt     <= cnt - CW'(1);
        end
        FINISH: begin
          bcd      <= scratch;
          sign     <= sign_l;
          overflow <= ovf_acc;
          done     <= 1'b1;
          busy     <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd.sv
// Scoreboard bench for bin2bcd: a 5-digit and a 4-digit instance share all stimulus.
module tb_bin2bcd;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] din;

  logic        busy, done, sign, overflow;
  logic [19:0] bcd;
  logic        busy4, done4, sign4, overflow4;
  logic [15:0] bcd4;

  always #5 clk = ~clk;

  bin2bcd #(.WIDTH(16), .DIGITS(5)) dut (
    .clk(clk), .reset(reset), .start(start), .din(din),
    .busy(busy), .done(done), .sign(sign), .bcd(bcd), .overflow(overflow)
  );

  bin2bcd #(.WIDTH(16), .DIGITS(4)) dut4 (
    .clk(clk), .reset(reset), .start(start), .din(din),
    .busy(busy4), .done(done4), .sign(sign4), .bcd(bcd4), .overflow(overflow4)
  );

  typedef struct {
    int          left;
    logic [19:0] bcd;
    logic        sgn;
    logic        ov5;
    logic        ov4;
  } exp_t;

  exp_t        q[$];
  exp_t        mdl_t;
  int          n_chk = 0;
  int          n_pass = 0;
  logic [19:0] last_bcd;
  logic        last_sgn, last_ov5, last_ov4;
  logic        exp_done, exp_busy;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  function automatic exp_t model(input logic [15:0] d);
    exp_t e;
    int   m;
    m      = d[15] ? 65536 - int'(d) : int'(d);
    e.left = 17;
    e.sgn  = d[15];
    e.ov5  = (m > 99999);
    e.ov4  = (m > 9999);
    e.bcd  = '0;
    for (int k = 0; k < 5; k++) begin
      e.bcd[4*k +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return e;
  endfunction

  // Reference timing model: an entry counts down to its done edge, then retires.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q.delete();
    end else begin
      if (q.size() > 0 && q[0].left == 0) begin
        void'(q.pop_front());
      end else if (q.size() > 0) begin
        mdl_t      = q[0];
        mdl_t.left = mdl_t.left - 1;
        q[0]       = mdl_t;
      end
      if (start && q.size() == 0) q.push_back(model(din));
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      last_bcd = '0; last_sgn = 1'b0; last_ov5 = 1'b0; last_ov4 = 1'b0;
      exp_done = 1'b0;
      exp_busy = 1'b0;
    end else begin
      exp_done = (q.size() > 0) && (q[0].left == 0);
      exp_busy = (q.size() > 0) && (q[0].left != 0);
      if (exp_done) begin
        last_bcd = q[0].bcd; last_sgn = q[0].sgn;
        last_ov5 = q[0].ov5; last_ov4 = q[0].ov4;
      end
    end
    check("done",      32'(done),      32'(exp_done));
    check("done4",     32'(done4),     32'(exp_done));
    check("busy",      32'(busy),      32'(exp_busy));
    check("busy4",     32'(busy4),     32'(exp_busy));
    check("bcd",       32'(bcd),       32'(last_bcd));
    check("sign",      32'(sign),      32'(last_sgn));
    check("overflow",  32'(overflow),  32'(last_ov5));
    check("bcd4",      32'(bcd4),      32'(last_bcd[15:0]));
    check("sign4",     32'(sign4),     32'(last_sgn));
    check("overflow4", 32'(overflow4), 32'(last_ov4));
  end

  task automatic wait_done();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = done;
    end
    check("done_timeout", 32'(seen), 32'd1);
  endtask

  task automatic run(input logic [15:0] v);
    @(posedge clk); #1;
    start = 1'b1; din = v;
    @(posedge clk); #1;
    start = 1'b0; din = 16'($urandom);
    wait_done();
  endtask

  logic [15:0] vecs [10] = '{16'd0, 16'd12345, 16'hFFFF, 16'h8000, 16'd32767,
                             16'd9999, 16'hCFC7, 16'd1, 16'd10000, 16'h7FF6};

  initial begin
    reset = 1'b1; start = 1'b0; din = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    foreach (vecs[i]) run(vecs[i]);
    for (int i = 0; i < 6; i++) run(16'($urandom));

    // start held high while busy with a changing din; then back-to-back on the done cycle
    @(posedge clk); #1;
    start = 1'b1; din = 16'd100;
    @(posedge clk); #1;
    din = 16'd200;
    repeat (10) @(posedge clk);
    #1 start = 1'b0;
    wait_done();
    start = 1'b1; din = 16'd7;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done();

    // reset mid-conversion with start held through reset
    @(posedge clk); #1;
    start = 1'b1; din = 16'd4321;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1 reset = 1'b1; start = 1'b1; din = 16'd555;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; din = '0;
    wait_done();

    run(16'd54321);
    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
